// File: rtl/hub75_bcm_sched_pkg.sv
// Shared HUB75 definitions: scheduler state encoding, log2 helper and plane one-hot decode.
package hub75_bcm_sched_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [ST_W-1:0] ST_SHIFT_GO   = 3'd1;
  localparam logic [ST_W-1:0] ST_SHIFT_WAIT = 3'd2;
  localparam logic [ST_W-1:0] ST_BLANK_WAIT = 3'd3;
  localparam logic [ST_W-1:0] ST_LATCH      = 3'd4;
  localparam logic [ST_W-1:0] ST_DISP_GO    = 3'd5;
  localparam logic [ST_W-1:0] ST_SWAP       = 3'd6;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned hub75_clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

  // Binary plane index to one-hot; callers truncate to their plane count.
  function automatic logic [31:0] plane_onehot(input logic [31:0] p);
    return 32'd1 << p;
  endfunction

endpackage

// File: rtl/hub75_bcm_sched_cnt.sv
// Row/plane position counter for the BCM scan, with look-ahead and frame-end flag.
module hub75_bcm_sched_cnt #(
  parameter int unsigned N_ROWS   = 32,
  parameter int unsigned N_PLANES = 8,
  parameter int unsigned ROW_W    = 5,
  parameter int unsigned PLANE_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               adv,
  output logic [ROW_W-1:0]   row,
  output logic [PLANE_W-1:0] plane,
  output logic [ROW_W-1:0]   row_nxt_c,
  output logic [PLANE_W-1:0] plane_nxt_c,
  output logic               frame_end_c
);

  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(N_PLANES - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(N_ROWS - 1);

  // Plane is the fast index; row carries on plane wrap and wraps naturally.
  always_comb begin
    row_nxt_c   = row;
    plane_nxt_c = plane;
    if (clr) begin
      row_nxt_c   = '0;
      plane_nxt_c = '0;
    end else if (adv) begin
      if (plane == PLANE_LAST) begin
        plane_nxt_c = '0;
        row_nxt_c   = row + ROW_W'(1);
      end else begin
        plane_nxt_c = plane + PLANE_W'(1);
      end
    end
  end

  assign frame_end_c = (plane == PLANE_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      row   <= '0;
      plane <= '0;
    end else begin
      row   <= row_nxt_c;
      plane <= plane_nxt_c;
    end
  end

endmodule

// File: rtl/hub75_bcm_sched.sv
// HUB75 scan/BCM sequencer: shifts plane p of row r, latches it, then starts its display.
// Optional framebuffer swap at frame end is built when HUB75_FB_SWAP_EN is defined.
module hub75_bcm_sched
  import hub75_bcm_sched_pkg::*;
#(
  parameter int unsigned N_ROWS     = 32,
  parameter int unsigned LOG_N_ROWS = 5,
  parameter int unsigned N_PLANES   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_run,
  output logic                  frame_start,
  output logic [LOG_N_ROWS-1:0] shift_row,
  output logic [N_PLANES-1:0]   shift_plane,
  output logic                  shift_go,
  input  logic                  shift_rdy,
  output logic [N_PLANES-1:0]   blank_plane,
  output logic                  blank_go,
  input  logic                  blank_rdy,
  output logic [LOG_N_ROWS-1:0] phy_addr,
  output logic                  phy_le
`ifdef HUB75_FB_SWAP_EN
  ,
  input  logic                  fb_swap_req,
  output logic                  fb_swap_ack
`endif
);

  localparam int unsigned PLANE_W = hub75_clog2(N_PLANES);

  logic [ST_W-1:0]       state, state_nxt;
  logic                  shift_skip;
  logic                  cnt_clr, cnt_adv;
  logic [LOG_N_ROWS-1:0] row, row_nxt_c;
  logic [PLANE_W-1:0]    plane, plane_nxt_c;
  logic                  frame_end_c;
`ifdef HUB75_FB_SWAP_EN
  logic                  swap_done;
`endif

  assign cnt_clr = (state_nxt == ST_IDLE);
  assign cnt_adv = (state == ST_DISP_GO);

  hub75_bcm_sched_cnt #(
    .N_ROWS   (N_ROWS),
    .N_PLANES (N_PLANES),
    .ROW_W    (LOG_N_ROWS),
    .PLANE_W  (PLANE_W)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_clr),
    .adv         (cnt_adv),
    .row         (row),
    .plane       (plane),
    .row_nxt_c   (row_nxt_c),
    .plane_nxt_c (plane_nxt_c),
    .frame_end_c (frame_end_c)
  );

  // Next state; ctrl_run is only honoured at IDLE and at the DISP_GO exit.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (ctrl_run && shift_rdy) state_nxt = ST_SHIFT_GO;
      ST_SHIFT_GO:   state_nxt = ST_SHIFT_WAIT;
      ST_SHIFT_WAIT: if (!shift_skip && shift_rdy) state_nxt = ST_BLANK_WAIT;
      ST_BLANK_WAIT: if (blank_rdy) state_nxt = ST_LATCH;
      ST_LATCH:      state_nxt = ST_DISP_GO;
      ST_DISP_GO: begin
        if (!ctrl_run) state_nxt = ST_IDLE;
`ifdef HUB75_FB_SWAP_EN
        else if (frame_end_c && fb_swap_req) state_nxt = ST_SWAP;
`endif
        else state_nxt = ST_SHIFT_GO;
      end
`ifdef HUB75_FB_SWAP_EN
      ST_SWAP:       if (swap_done) state_nxt = ST_SHIFT_GO;
`endif
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Registered outputs, decoded from the state being entered so each pulse lines up with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_skip  <= 1'b0;
      frame_start <= 1'b0;
      shift_row   <= '0;
      shift_plane <= '0;
      shift_go    <= 1'b0;
      blank_plane <= '0;
      blank_go    <= 1'b0;
      phy_addr    <= '0;
      phy_le      <= 1'b0;
`ifdef HUB75_FB_SWAP_EN
      swap_done   <= 1'b0;
      fb_swap_ack <= 1'b0;
`endif
    end else begin
      shift_skip  <= (state == ST_SHIFT_GO);
      shift_go    <= (state_nxt == ST_SHIFT_GO);
      frame_start <= (state_nxt == ST_SHIFT_GO) && ((state != ST_DISP_GO) || frame_end_c);
      phy_le      <= (state_nxt == ST_LATCH);
      blank_go    <= (state_nxt == ST_DISP_GO);
      if (state_nxt == ST_SHIFT_GO) begin
        shift_row   <= row_nxt_c;
        shift_plane <= N_PLANES'(plane_onehot(32'(plane_nxt_c)));
      end
      if (state_nxt == ST_LATCH) begin
        phy_addr    <= row;
        blank_plane <= N_PLANES'(plane_onehot(32'(plane)));
      end
`ifdef HUB75_FB_SWAP_EN
      // Ack once the panel is blanked, then leave SWAP on the following cycle.
      swap_done   <= (state == ST_SWAP) && (swap_done || blank_rdy);
      fb_swap_ack <= (state == ST_SWAP) && blank_rdy && !swap_done;
`endif
    end
  end

endmodule
